sm_serial_subtractor: RTL and testbench
=======================================

// Module: sm_serial_subtractor
// PURPOSE
//  Sequential counterpart to the combinational 8-bit adder in this assignment set.
//  Accepts two sign-magnitude operands and converts them to two's complement.
//  Computes a - b bit-serially, LSB first, one bit per clock, with a start/busy/done handshake.
//  Returns the difference as a registered two's-complement word plus an overflow flag.
// PARAMETERS
//  WIDTH  8  operand/result width; bit WIDTH-1 = sign, [WIDTH-2:0] = magnitude
// PORTS
//  clk     in   1      single clock, all state updates on rising edge
//  rst     in   1      reset, asynchronous, active-high
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend, sign-magnitude
//  b       in   WIDTH  subtrahend, sign-magnitude
//  busy    out  1      high while an operation is in CONV or SHIFT
//  done    out  1      one-cycle pulse: result/ovf valid
//  result  out  WIDTH  a - b, two's complement, held until next done
//  ovf     out  1      signed overflow of result, held with result
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, ovf=0.
//    All internal regs (operand, shift, count, carry) are also cleared.
//  FSM states: IDLE -> CONV -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
//  IDLE: on start=1, latch a,b into operand regs and go to CONV. Otherwise stay.
//  CONV (1 cycle):
//    - Convert each operand: sign=0 -> {0,mag}; sign=1 -> -{0,mag}.
//    - -0 (sign=1, mag=0) maps to 0.
//    - Load A=conv(a), B=~conv(b), carry=1, count=0. Go to SHIFT.
//  SHIFT: each cycle, sum_i = A[0]^B[0]^carry.
//    - carry' = majority(A[0], B[0], carry).
//    - sum_i shifts in at the MSB of the result shift reg; A and B shift right.
//    - On count==WIDTH-1, record c_in_msb = carry (before update) and c_out = carry'. Go to DONE.
//  DONE (1 cycle): result <= shift reg; ovf <= c_in_msb ^ c_out; done=1. Next state IDLE.
//  busy: 1 in CONV and SHIFT, 0 in IDLE and DONE. done is 1 only in DONE.
//  Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH+1.
//    For WIDTH=8, done is high for the cycle after E9.
//    Throughput is one op per WIDTH+3 cycles.
//  Operand range: +/-(2^(WIDTH-1)-1). Difference range: +/-(2^WIDTH-2).
//    Results outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] set ovf=1.
//    In that case, result = low WIDTH bits of the true difference.
//  start while busy or in DONE: ignored, no effect on the in-flight op.
//    A start held high continuously re-triggers from IDLE each time.
//  a/b changes after E0: no effect; operands are latched.
//  result/ovf change only on DONE entry. They are stable at all other times.
//  rst mid-operation: op abandoned, outputs cleared, no done pulse.
//    A new start is accepted as soon as rst deasserts.
// TESTING (WIDTH=8, values hex)
//  1 a=05, b=03, start 1 cycle -> done exactly 1 cycle after E9; result=02, ovf=0.
//    Check busy high E0..E9.
//  2 a=85 (-5), b=03 -> result=F8 (-8), ovf=0.
//    Also a=FF (-127), b=01 -> result=80 (-128), ovf=0 (boundary, no overflow).
//  3 a=64 (+100), b=E4 (-100) -> result=C8, ovf=1.
//    Also a=E4, b=64 -> result=38, ovf=1.
//  4 a=80 (-0), b=00 -> result=00, ovf=0. Also a=00, b=80 -> result=00, ovf=0.
//  5 Pulse start with new operands at E3 and during DONE -> ignored; original result.
//    Then back-to-back ops with start held high -> two correct results, WIDTH+3 cycles apart.
//  6 Assert rst during SHIFT (count=4) -> busy/done/result/ovf=0 immediately, before the next edge.
//    After release, a=05, b=07 -> result=FE, ovf=0.

Source files
------------

// File: rtl/sm_serial_subtractor.sv
// Bit-serial a - b on sign-magnitude operands: converts to two's complement, then
// subtracts LSB first, one bit per clock, with a start/busy/done handshake.
module sm_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sum_bit, carry_nxt, last_bit;

  // Negating a zero magnitude wraps back to zero, so -0 needs no special case.
  function automatic logic [WIDTH-1:0] to_twos(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] mag;
    mag = {1'b0, x[WIDTH-2:0]};
    return x[WIDTH-1] ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign last_bit  = (count_q == CW'(WIDTH - 1));

  // FSM: state register
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state logic
  // NOTE: assigning a default before the case keeps every path covered, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    busy = (state_q == CONV) || (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath next-state; result/ovf commit on the final SHIFT edge, i.e. on DONE entry.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    shift_d  = shift_q;
    count_d  = count_q;
    carry_d  = carry_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d = a;
          opb_d = b;
        end
      end
      CONV: begin
        opa_d   = to_twos(opa_q);
        opb_d   = ~to_twos(opb_q);
        carry_d = 1'b1;
        count_d = '0;
        shift_d = '0;
      end
      SHIFT: begin
        shift_d = {sum_bit, shift_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = carry_nxt;
        count_d = count_q + CW'(1);
        if (last_bit) begin
          result_d = {sum_bit, shift_q[WIDTH-1:1]};
          ovf_d    = carry_q ^ carry_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sm_serial_subtractor.sv
// Scoreboard bench for sm_serial_subtractor (WIDTH=8): expectations are queued at
// start and compared whenever done pulses.
module tb_sm_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, ovf;
  logic [W-1:0] result;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  sm_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: true signed difference of the sign-magnitude values.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t e;
    int   va, vb, diff;
    va = xa[W-1] ? -int'(xa[W-2:0]) : int'(xa[W-2:0]);
    vb = xb[W-1] ? -int'(xb[W-2:0]) : int'(xb[W-2:0]);
    diff = va - vb;
    e.res = diff[W-1:0];
    e.ovf = (diff > 127) || (diff < -128);
    e.a = xa;
    e.b = xb;
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      check("done_width", {31'd0, prev_done}, 32'd0);
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("result a=%h b=%h", e.a, e.b), {24'd0, result}, {24'd0, e.res});
        check($sformatf("ovf a=%h b=%h", e.a, e.b), {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
    prev_done <= done & ~rst;
  end

  // Drive start for one cycle; returns just after the sampling edge E0.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit expect_done);
    @(posedge clk) #1;
    a = xa;
    b = xb;
    start = 1'b1;
    if (expect_done) exp_q.push_back(model(xa, xb));
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb);
    start_op(xa, xb, 1'b1);
    wait_done();
  endtask

  initial begin
    int busy_bad;
    int n_done;

    // Reset state
    #2;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_ovf",    {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic op with latency and busy window
    start_op(8'h05, 8'h03, 1'b1);
    busy_bad = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    check("busy_window", busy_bad, 0);
    @(negedge clk);
    check("done_latency", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk);

    // Sign handling, boundaries, overflow, negative zero
    run_op(8'h85, 8'h03);
    run_op(8'hFF, 8'h01);
    run_op(8'h64, 8'hE4);
    run_op(8'hE4, 8'h64);
    run_op(8'h80, 8'h00);
    run_op(8'h00, 8'h80);
    run_op(8'h7F, 8'hFF);
    run_op(8'h00, 8'h7F);

    // Ignored start pulses mid-op and in DONE; operand changes after E0
    n_done = done_cyc.size();
    start_op(8'h05, 8'h03, 1'b1);
    a = 8'h44; b = 8'h99;
    @(posedge clk) #1;                      // after E1
    @(posedge clk) #1;                      // after E2
    start = 1'b1;
    @(posedge clk) #1;                      // after E3
    start = 1'b0;
    repeat (6) @(posedge clk);              // E9: enter DONE
    #1 start = 1'b1;
    @(posedge clk) #1;                      // E10: DONE -> IDLE, start ignored
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("ignored_start_dones", done_cyc.size() - n_done, 1);
    check("state_idle_after", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high
    n_done = done_cyc.size();
    @(posedge clk) #1;
    a = 8'h10; b = 8'h20;
    start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20));
    exp_q.push_back(model(8'hA0, 8'h15));
    @(posedge clk) #1;                      // after first E0
    a = 8'hA0; b = 8'h15;
    wait_done();                            // returns at E10
    @(posedge clk) #1;                      // after E11 (second E0)
    start = 1'b0;
    wait_done();
    if (done_cyc.size() - n_done == 2)
      check("b2b_spacing", done_cyc[n_done+1] - done_cyc[n_done], W + 3);
    else
      check("b2b_done_count", done_cyc.size() - n_done, 2);

    // Reset during SHIFT (count=4) clears outputs immediately
    start_op(8'h33, 8'h11, 1'b0);           // returns after E0
    repeat (5) @(posedge clk);              // E5: count becomes 4
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_result", {24'd0, result}, 32'd0);
    check("midrst_ovf",    {31'd0, ovf}, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    run_op(8'h05, 8'h07);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
